// File: rtl/dmem_mmio_pkg.sv
// Shared constants and types for the data-memory/MMIO responder.
package dmem_mmio_pkg;

    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_CYCLE  = 8'h08;
    localparam logic [7:0] OFF_ERRCLR = 8'h0C;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_ERR       = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        RAM,
        MMIO_TX,
        MMIO_STATUS,
        MMIO_CYCLE,
        MMIO_ERRCLR,
        MMIO_NONE
    } decode_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head (no fall-through); accepts a push when full if a pop happens.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus MMIO window with console TX FIFO, cycle counter and sticky error flags.
module dmem_mmio_responder
    import dmem_mmio_pkg::*;
#(
    parameter int          RAM_ADDR_W = 6,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_wmem_i,
    input  logic [31:0] addr_i32,
    input  logic [31:0] write_data_i32,
    output logic [31:0] read_data_o32,
    output logic [7:0]  tx_data_o8,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]          ram [2**RAM_ADDR_W];
    logic [RAM_ADDR_W-1:0] ram_idx;
    decode_t              tgt;
    logic                 wr_aligned;
    logic                 misaligned_wr;
    logic                 push_req;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [31:0]          cycle_q;
    logic                 err_q;
    logic                 ovf_q;
    logic [31:0]          status;

    assign ram_idx       = addr_i32[RAM_ADDR_W+1:2];
    assign wr_aligned    = enable_wmem_i && (addr_i32[1:0] == 2'b00);
    assign misaligned_wr = enable_wmem_i && (addr_i32[1:0] != 2'b00);
    assign push_req      = wr_aligned && (tgt == MMIO_TX);
    assign tx_valid_o    = !fifo_empty;
    assign pop           = tx_valid_o && tx_ready_i;

    // Byte-lane bits are ignored for decode so reads at any byte offset hit the word.
    always_comb begin
        tgt = RAM;
        if (addr_i32[31:8] == MMIO_BASE[31:8]) begin
            case ({addr_i32[7:2], 2'b00})
                OFF_TXDATA: tgt = MMIO_TX;
                OFF_STATUS: tgt = MMIO_STATUS;
                OFF_CYCLE:  tgt = MMIO_CYCLE;
                OFF_ERRCLR: tgt = MMIO_ERRCLR;
                default:    tgt = MMIO_NONE;
            endcase
        end
    end

    always_comb begin
        status                          = '0;
        status[ST_EMPTY]                = fifo_empty;
        status[ST_FULL]                 = fifo_full;
        status[ST_ERR]                  = err_q;
        status[ST_OVF]                  = ovf_q;
        status[ST_COUNT_LSB +: 8]       = 8'(fifo_count);
    end

    always_comb begin
        read_data_o32 = '0;
        case (tgt)
            RAM:         read_data_o32 = ram[ram_idx];
            MMIO_STATUS: read_data_o32 = status;
            MMIO_CYCLE:  read_data_o32 = cycle_q;
            default:     read_data_o32 = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_aligned && tgt == RAM) ram[ram_idx] <= write_data_i32;
    end

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_aligned && tgt == MMIO_CYCLE) cycle_q <= write_data_i32;
            else                                 cycle_q <= cycle_q + 32'd1;

            if (misaligned_wr)                          err_q <= 1'b1;
            else if (wr_aligned && tgt == MMIO_ERRCLR)  err_q <= 1'b0;

            if (push_req && fifo_full && !pop)          ovf_q <= 1'b1;
            else if (wr_aligned && tgt == MMIO_ERRCLR)  ovf_q <= 1'b0;
        end
    end

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk_i),
        .rst       (reset_i),
        .push      (push_req),
        .push_data (write_data_i32[7:0]),
        .pop       (pop),
        .head_data (tx_data_o8),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
